// File: rtl/mole_autoplayer_if.sv
// Game <-> autoplayer signal bundle.
// master: the game side (drives enable/mole/game_state/lives, observes button/hits/busy).
// slave:  the autoplayer.
interface mole_autoplayer_if;
    logic       enable;
    logic [3:0] mole;
    logic [2:0] game_state;
    logic [1:0] lives;
    logic [3:0] button;
    logic [7:0] hits;
    logic       busy;

    modport master (
        output enable, mole, game_state, lives,
        input  button, hits, busy
    );

    modport slave (
        input  enable, mole, game_state, lives,
        output button, hits, busy
    );
endinterface

// File: rtl/mole_autoplayer.sv
// Whack-a-mole autoplayer: watches the mole lines, waits a reaction delay,
// presses the matching button, then waits for the mole to drop.
// In IDLE/END game states it keeps pressing button 0 to start a game.
// Optional build macro AUTOPLAY_MISS_EN: every 4th target acquisition is
// deliberately skipped (no press, hits unchanged).
module mole_autoplayer #(
    parameter int unsigned REACT_CYCLES    = 8,
    parameter int unsigned PRESS_CYCLES    = 2,
    parameter int unsigned RELEASE_TIMEOUT = 64,
    parameter logic [2:0]  GS_IDLE         = 3'd0,
    parameter logic [2:0]  GS_PLAY         = 3'd1,
    parameter logic [2:0]  GS_END          = 3'd2
) (
    input logic              clk,
    input logic              reset,
    mole_autoplayer_if.slave bus
);

    typedef enum logic [2:0] {SCAN, REACT, PRESS, RELEASE, START} state_t;

    state_t     state_q, state_d;
    logic [1:0] tgt_q, tgt_d;
    logic [7:0] cnt_q, cnt_d;
    logic       hit_ok_q, hit_ok_d;
    logic [3:0] button_q, button_d;
    logic [7:0] hits_q, hits_d;
    logic       busy_q;

    logic [1:0] low_idx;
    logic       mole_tgt;
    logic       hit_now;
    logic       skipping;
    logic       acquire;

`ifdef AUTOPLAY_MISS_EN
    logic [1:0] miss_cnt_q, miss_cnt_d;
    logic       skip_q, skip_d;
    assign skipping = skip_q;
`else
    assign skipping = 1'b0;
`endif

    assign mole_tgt = bus.mole[tgt_q];
    assign acquire  = (bus.game_state == GS_PLAY) && (bus.mole != '0) &&
                      (bus.lives != '0) && !skipping;
    // First press cycle samples the mole directly; later cycles use the stored flag.
    assign hit_now  = (cnt_q == 8'd1) ? mole_tgt : hit_ok_q;

    // Lowest visible mole lane.
    always_comb begin
        casez (bus.mole)
            4'b???1: low_idx = 2'd0;
            4'b??10: low_idx = 2'd1;
            4'b?100: low_idx = 2'd2;
            default: low_idx = 2'd3;
        endcase
    end

    // Next-state, counter, button and hit-count logic.
    always_comb begin
        state_d  = state_q;
        tgt_d    = tgt_q;
        cnt_d    = cnt_q;
        hit_ok_d = hit_ok_q;
        button_d = '0;
        hits_d   = hits_q;
`ifdef AUTOPLAY_MISS_EN
        miss_cnt_d = miss_cnt_q;
        skip_d     = skip_q;
`endif
        if (!bus.enable) begin
            state_d  = SCAN;
            tgt_d    = '0;
            cnt_d    = '0;
            hit_ok_d = 1'b0;
`ifdef AUTOPLAY_MISS_EN
            skip_d   = 1'b0;
`endif
        end else begin
            case (state_q)
                SCAN: begin
`ifdef AUTOPLAY_MISS_EN
                    if (skip_q && !mole_tgt) skip_d = 1'b0;
`endif
                    if (bus.game_state == GS_IDLE || bus.game_state == GS_END) begin
                        state_d  = START;
                        tgt_d    = '0;
                        cnt_d    = 8'd1;
                        button_d = 4'b0001;
`ifdef AUTOPLAY_MISS_EN
                        skip_d   = 1'b0;
`endif
                    end else if (acquire) begin
                        tgt_d = low_idx;
`ifdef AUTOPLAY_MISS_EN
                        miss_cnt_d = miss_cnt_q + 2'd1;
                        if (miss_cnt_q == 2'd3) begin
                            skip_d = 1'b1;
                        end else begin
                            state_d = REACT;
                            cnt_d   = 8'd1;
                        end
`else
                        state_d = REACT;
                        cnt_d   = 8'd1;
`endif
                    end
                end
                REACT: begin
                    if (!mole_tgt) begin
                        state_d = SCAN;
                        cnt_d   = '0;
                    end else if (cnt_q == 8'(REACT_CYCLES)) begin
                        state_d  = PRESS;
                        cnt_d    = 8'd1;
                        button_d = 4'b0001 << tgt_q;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                PRESS: begin
                    if (cnt_q == 8'd1) hit_ok_d = mole_tgt;
                    if (cnt_q == 8'(PRESS_CYCLES)) begin
                        state_d = RELEASE;
                        cnt_d   = 8'd1;
                        if (hit_now && hits_q != 8'hFF) hits_d = hits_q + 8'd1;
                    end else begin
                        cnt_d    = cnt_q + 8'd1;
                        button_d = 4'b0001 << tgt_q;
                    end
                end
                RELEASE: begin
                    if (!mole_tgt || cnt_q == 8'(RELEASE_TIMEOUT)) begin
                        state_d = SCAN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                START: begin
                    if (cnt_q == 8'(PRESS_CYCLES)) begin
                        state_d = SCAN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d    = cnt_q + 8'd1;
                        button_d = 4'b0001;
                    end
                end
                default: begin
                    state_d = SCAN;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // State and output registers; button and busy are registered from next-state values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= SCAN;
            tgt_q    <= '0;
            cnt_q    <= '0;
            hit_ok_q <= 1'b0;
            button_q <= '0;
            hits_q   <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            tgt_q    <= tgt_d;
            cnt_q    <= cnt_d;
            hit_ok_q <= hit_ok_d;
            button_q <= button_d;
            hits_q   <= hits_d;
            busy_q   <= (state_d != SCAN);
        end
    end

`ifdef AUTOPLAY_MISS_EN
    // Acquisition counter and skip flag for deliberate misses.
    always_ff @(posedge clk) begin
        if (reset) begin
            miss_cnt_q <= '0;
            skip_q     <= 1'b0;
        end else begin
            miss_cnt_q <= miss_cnt_d;
            skip_q     <= skip_d;
        end
    end
`endif

    assign bus.button = button_q;
    assign bus.hits   = hits_q;
    assign bus.busy   = busy_q;

endmodule

// File: tb/tb_mole_autoplayer.sv
// Directed testbench for mole_autoplayer (default parameters).
// Outputs are sampled and inputs driven on the falling clock edge.
module tb_mole_autoplayer;

    localparam logic [2:0] GS_IDLE = 3'd0;
    localparam logic [2:0] GS_PLAY = 3'd1;
    localparam logic [2:0] GS_END  = 3'd2;

`ifdef AUTOPLAY_MISS_EN
    localparam int EXP_E = 6;
`else
    localparam int EXP_E = 8;
`endif

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    mole_autoplayer_if bus ();

    mole_autoplayer #(
        .REACT_CYCLES   (8),
        .PRESS_CYCLES   (2),
        .RELEASE_TIMEOUT(64)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       en;
        logic [3:0] mole;
        logic [2:0] gs;
        logic [1:0] lives;
        logic [3:0] eb;
        logic [7:0] eh;
        logic       ebusy;
    } vec_t;

    vec_t       vt[12];
    logic [3:0] rb[80];
    logic       rbusy[80];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Compare recorded button/busy traces of length n against expected per-index values.
    task automatic check_trace(input string name, input int n,
                               input logic [3:0] eb[80], input logic ebz[80]);
        int bad = 0;
        int first = -1;
        for (int k = 0; k < n; k++) begin
            if (rb[k] !== eb[k] || rbusy[k] !== ebz[k]) begin
                bad++;
                if (first < 0) first = k;
            end
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL %s: cycle %0d button=%b busy=%b expected button=%b busy=%b (%0d bad cycles)",
                     name, first, rb[first], rbusy[first], eb[first], ebz[first], bad);
        end
    endtask

    task automatic rst_seq();
        reset          = 1'b1;
        bus.enable     = 1'b1;
        bus.mole       = '0;
        bus.game_state = GS_PLAY;
        bus.lives      = 2'd3;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic record(input int n, input int chg_at, input logic [3:0] chg_val);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            rb[k]    = bus.button;
            rbusy[k] = bus.busy;
            if (k == chg_at) bus.mole = chg_val;
        end
    endtask

    // One mole appearance: held 12 cycles, then dropped for 2; counts press starts.
    task automatic one_mole(input logic [3:0] m, inout int presses, inout int multi);
        logic [3:0] prev = '0;
        bus.mole = m;
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            if (bus.button != '0 && prev == '0) presses++;
            if ($countones(bus.button) > 1) multi++;
            prev = bus.button;
            if (k == 11) bus.mole = '0;
        end
    endtask

    initial begin
        logic [3:0] eb[80];
        logic       ebz[80];
        int         presses;
        int         multi;

        vt[0]  = '{1'b1, 1'b1, 4'b0000, GS_IDLE, 2'd3, 4'b0000, 8'd0, 1'b0};
        vt[1]  = '{1'b0, 1'b1, 4'b0000, GS_IDLE, 2'd3, 4'b0001, 8'd0, 1'b1};
        vt[2]  = '{1'b0, 1'b1, 4'b0000, GS_IDLE, 2'd3, 4'b0001, 8'd0, 1'b1};
        vt[3]  = '{1'b0, 1'b1, 4'b0000, GS_IDLE, 2'd3, 4'b0000, 8'd0, 1'b0};
        vt[4]  = '{1'b0, 1'b1, 4'b0000, GS_PLAY, 2'd3, 4'b0000, 8'd0, 1'b0};
        vt[5]  = '{1'b0, 1'b1, 4'b0100, GS_PLAY, 2'd0, 4'b0000, 8'd0, 1'b0};
        vt[6]  = '{1'b0, 1'b1, 4'b0100, GS_PLAY, 2'd0, 4'b0000, 8'd0, 1'b0};
        vt[7]  = '{1'b1, 1'b1, 4'b0000, GS_END,  2'd3, 4'b0000, 8'd0, 1'b0};
        vt[8]  = '{1'b0, 1'b1, 4'b0000, GS_END,  2'd3, 4'b0001, 8'd0, 1'b1};
        vt[9]  = '{1'b0, 1'b0, 4'b0000, GS_END,  2'd3, 4'b0000, 8'd0, 1'b0};
        vt[10] = '{1'b0, 1'b0, 4'b0100, GS_PLAY, 2'd3, 4'b0000, 8'd0, 1'b0};
        vt[11] = '{1'b0, 1'b1, 4'b0000, 3'd5,    2'd3, 4'b0000, 8'd0, 1'b0};

        for (int i = 0; i < 12; i++) begin
            reset          = vt[i].rst;
            bus.enable     = vt[i].en;
            bus.mole       = vt[i].mole;
            bus.game_state = vt[i].gs;
            bus.lives      = vt[i].lives;
            @(negedge clk);
            check($sformatf("vec%0d {button,hits,busy}", i),
                  {19'd0, bus.button, bus.hits, bus.busy},
                  {19'd0, vt[i].eb, vt[i].eh, vt[i].ebusy});
        end

        // Held mole: press 8 clocks after detection, release timeout, reacquire, abort.
        rst_seq();
        bus.mole = 4'b0100;
        record(80, 79, 4'b0000);
        for (int k = 0; k < 80; k++) begin
            eb[k]  = (k == 8 || k == 9) ? 4'b0100 : 4'b0000;
            ebz[k] = (k != 74);
        end
        check_trace("a_hold_trace", 80, eb, ebz);
        @(negedge clk);
        check("a_abort_busy", {31'd0, bus.busy}, 32'd0);
        check("a_hits", {24'd0, bus.hits}, 32'd1);

        // Lowest lane wins; new lane raised during RELEASE waits for SCAN.
        rst_seq();
        bus.mole = 4'b1010;
        record(30, 10, 4'b0001);
        bus.mole = '0;
        for (int k = 0; k < 30; k++) begin
            eb[k]  = (k == 8 || k == 9) ? 4'b0010 :
                     (k == 20 || k == 21) ? 4'b0001 : 4'b0000;
            ebz[k] = (k != 11);
        end
        check_trace("b_lane_trace", 30, eb, ebz);
        @(negedge clk);
        check("b_busy_after", {31'd0, bus.busy}, 32'd0);
        check("b_hits", {24'd0, bus.hits}, 32'd2);

        // Mole drops during REACT: no press.
        rst_seq();
        bus.mole = 4'b0001;
        record(10, 3, 4'b0000);
        for (int k = 0; k < 10; k++) begin
            eb[k]  = 4'b0000;
            ebz[k] = (k < 4);
        end
        check_trace("c_abort_trace", 10, eb, ebz);
        check("c_hits", {24'd0, bus.hits}, 32'd0);

        // Reset mid-press, then enable low mid-REACT.
        rst_seq();
        bus.mole = 4'b1000;
        repeat (9) @(negedge clk);
        check("d_press_lane3", {28'd0, bus.button}, 32'h8);
        reset = 1'b1;
        @(negedge clk);
        check("d_reset_midpress", {19'd0, bus.button, bus.hits, bus.busy}, 32'd0);
        reset    = 1'b0;
        bus.mole = 4'b0100;
        repeat (12) @(negedge clk);
        bus.mole = '0;
        repeat (2) @(negedge clk);
        check("d_hits_before_disable", {24'd0, bus.hits}, 32'd1);
        bus.mole = 4'b0010;
        repeat (4) @(negedge clk);
        bus.enable = 1'b0;
        @(negedge clk);
        check("d_disable_react", {19'd0, bus.button, bus.hits, bus.busy}, {19'd0, 4'b0000, 8'd1, 1'b0});
        record(12, -1, 4'b0010);
        for (int k = 0; k < 12; k++) begin
            eb[k]  = 4'b0000;
            ebz[k] = 1'b0;
        end
        check_trace("d_disabled_quiet", 12, eb, ebz);
        bus.enable = 1'b1;
        bus.mole   = '0;

        // Eight sequential single-mole appearances.
        rst_seq();
        presses = 0;
        multi   = 0;
        for (int i = 0; i < 8; i++) begin
            logic [3:0] m;
            m = 4'b0001 << (i % 4);
            one_mole(m, presses, multi);
        end
        check("e_hits", {24'd0, bus.hits}, EXP_E);
        check("e_presses", presses, EXP_E);
        check("e_onehot", multi, 0);

        // Saturation of the hit counter.
        for (int i = 0; i < 350; i++) begin
            logic [3:0] m;
            m = 4'b0001 << (i % 4);
            one_mole(m, presses, multi);
        end
        check("f_hits_saturate", {24'd0, bus.hits}, 32'd255);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
